// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronizes and debounces the A/B pins, decodes
// Gray-code moves into one-cycle step/dir pulses and flags double-bit jumps.
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int X1_MODE         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [1:0] ab_state
);

  localparam logic [8:0] RUN_DONE = 9'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0] SETTLE   = 9'(DEBOUNCE_CYCLES + 2);

  typedef enum logic [1:0] {MV_NONE, MV_CW, MV_CCW, MV_ILL} move_t;
  typedef enum logic {S_INIT, S_TRACK} state_t;

  function automatic move_t classify(input logic [1:0] prev_v, input logic [1:0] next_v);
    case ({prev_v, next_v})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: classify = MV_CW;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: classify = MV_CCW;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: classify = MV_ILL;
      default:                            classify = MV_NONE;
    endcase
  endfunction

  // In x1 mode only the detent crossing counts; the only legal arrivals at 00
  // are 10->00 (CW) and 01->00 (CCW).
  function automatic logic emits_step(input logic [1:0] next_v);
    emits_step = (X1_MODE == 0) || (next_v == 2'b00);
  endfunction

  // Stage p0/p1: two-flop synchronizer per channel
  logic [1:0] ab_p0;
  logic [1:0] sync_ab;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ab_p0   <= 2'b00;
      sync_ab <= 2'b00;
    end else begin
      ab_p0   <= {a_in, b_in};
      sync_ab <= ab_p0;
    end
  end

  // Stage p2: debounce filter
  // run is the number of earlier consecutive cycles sync_ab has shown its
  // current value while differing from filt_ab; acceptance needs DEBOUNCE_CYCLES
  // such cycles including the present one.
  logic [1:0] cand;
  logic [1:0] filt_ab;
  logic [7:0] cnt;
  logic [8:0] run;
  logic       accept;
  logic       vld_p2;

  always_comb begin
    run    = 9'd0;
    accept = 1'b0;
    if (sync_ab != filt_ab) begin
      if (sync_ab == cand) run = {1'b0, cnt} + 9'd1;
      accept = (run >= RUN_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cand    <= 2'b00;
      cnt     <= 8'd0;
      filt_ab <= 2'b00;
      vld_p2  <= 1'b0;
    end else begin
      cand   <= sync_ab;
      vld_p2 <= accept;
      if (accept) begin
        filt_ab <= sync_ab;
        cnt     <= 8'd0;
      end else begin
        cnt <= run[7:0];
      end
    end
  end

  assign ab_state = filt_ab;

  // Stage p3: decode FSM and registered outputs
  state_t     state;
  state_t     state_nx;
  logic [1:0] prev_ab;
  logic [1:0] prev_nx;
  logic [8:0] settle;
  logic       step_nx;
  logic       dir_nx;
  logic       err_nx;
  move_t      mv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_INIT;
      prev_ab <= 2'b00;
      settle  <= 9'd0;
      step    <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      prev_ab <= prev_nx;
      step    <= step_nx;
      dir     <= dir_nx;
      err     <= err_nx;
      if (state == S_INIT && settle < SETTLE) settle <= settle + 9'd1;
    end
  end

  // INIT adopts the first accepted value silently; if the pins rest at the reset
  // value 00 nothing is ever accepted, so once the synchronizer and one debounce
  // window have elapsed with no pending change, 00 itself is adopted.
  always_comb begin
    state_nx = state;
    prev_nx  = prev_ab;
    step_nx  = 1'b0;
    dir_nx   = dir;
    err_nx   = 1'b0;
    mv       = classify(prev_ab, filt_ab);
    case (state)
      S_INIT: begin
        if (vld_p2 || (settle >= SETTLE && sync_ab == filt_ab)) begin
          prev_nx  = filt_ab;
          state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (vld_p2) begin
          prev_nx = filt_ab;
          case (mv)
            MV_CW: begin
              if (emits_step(filt_ab)) begin
                step_nx = 1'b1;
                dir_nx  = 1'b0;
              end
            end
            MV_CCW: begin
              if (emits_step(filt_ab)) begin
                step_nx = 1'b1;
                dir_nx  = 1'b1;
              end
            end
            MV_ILL:  err_nx = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: three configurations driven from the same pins and
// compared every cycle against a pin-history reference model, plus scenario checks.
module tb_quad_step_decoder;

  logic clk;
  logic rst;
  logic a_in;
  logic b_in;
  logic step0, dir0, err0;
  logic step1, dir1, err1;
  logic step2, dir2, err2;
  logic [1:0] ab0, ab1, ab2;
  logic [4:0] obs [3];
  logic [3:0] cnt4;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_step_decoder #(.DEBOUNCE_CYCLES(4), .X1_MODE(0)) u0 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .step(step0), .dir(dir0), .err(err0), .ab_state(ab0));
  quad_step_decoder #(.DEBOUNCE_CYCLES(4), .X1_MODE(1)) u1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .step(step1), .dir(dir1), .err(err1), .ab_state(ab1));
  quad_step_decoder #(.DEBOUNCE_CYCLES(1), .X1_MODE(0)) u2 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .step(step2), .dir(dir2), .err(err2), .ab_state(ab2));

  assign obs[0] = {step0, dir0, err0, ab0};
  assign obs[1] = {step1, dir1, err1, ab1};
  assign obs[2] = {step2, dir2, err2, ab2};

  // Downstream 4-bit up/down counter stage, sampling on negedge.
  always @(negedge clk) begin
    if (!rst) cnt4 <= 4'd0;
    else if (step0) cnt4 <= dir0 ? cnt4 - 4'd1 : cnt4 + 4'd1;
  end

  // Reference model: pin history plus per-configuration filtered/decoded state.
  int         dpar [3] = '{4, 4, 1};
  bit         x1par [3] = '{1'b0, 1'b1, 1'b0};
  logic [1:0] hq [$];
  logic [1:0] m_filt [3];
  logic [1:0] m_prev [3];
  logic [1:0] m_pendv [3];
  bit         m_track [3];
  bit         m_pend [3];
  bit         m_dir [3];
  bit         m_step [3];
  bit         m_err [3];
  int         m_n [3];
  logic [4:0] expv [3];

  // Scenario statistics gathered by hold().
  int nstep [3];
  int ndn [3];
  int nerr [3];
  int mm, mm_u, mm_k, kedge, first_k;
  logic [4:0] mm_got, mm_want;

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   pos = 0;
      2'b01:   pos = 1;
      2'b11:   pos = 2;
      default: pos = 3;
    endcase
  endfunction

  task automatic model_edge(input logic [1:0] p, input logic r);
    logic [1:0] s;
    bit stable;
    int dlt;
    int idx;
    if (!r) begin
      hq.delete();
      hq.push_back(2'b00);
      hq.push_back(2'b00);
      for (int i = 0; i < 3; i++) begin
        m_filt[i] = 2'b00; m_prev[i] = 2'b00; m_pendv[i] = 2'b00;
        m_track[i] = 1'b0; m_pend[i] = 1'b0; m_dir[i] = 1'b0;
        m_step[i] = 1'b0; m_err[i] = 1'b0; m_n[i] = 0;
        expv[i] = 5'b0;
      end
    end else begin
      hq.push_back(p);
      if (hq.size() > 300) void'(hq.pop_front());
      s = hq[hq.size() - 3];
      for (int i = 0; i < 3; i++) begin
        m_n[i]++;
        m_step[i] = 1'b0;
        m_err[i] = 1'b0;
        if (m_pend[i]) begin
          if (!m_track[i]) begin
            m_track[i] = 1'b1;
          end else begin
            dlt = (pos(m_pendv[i]) - pos(m_prev[i]) + 4) % 4;
            if (dlt == 2) m_err[i] = 1'b1;
            else if (dlt != 0 && (!x1par[i] || m_pendv[i] == 2'b00)) begin
              m_step[i] = 1'b1;
              m_dir[i] = (dlt == 3);
            end
          end
          m_prev[i] = m_pendv[i];
        end else if (!m_track[i] && m_n[i] > dpar[i] + 3) begin
          m_track[i] = 1'b1;
          m_prev[i] = m_filt[i];
        end
        m_pend[i] = 1'b0;
        stable = (s != m_filt[i]);
        for (int j = 0; j < dpar[i]; j++) begin
          idx = hq.size() - 3 - j;
          if (idx < 0) stable = 1'b0;
          else if (hq[idx] != s) stable = 1'b0;
        end
        if (stable) begin
          m_filt[i] = s;
          m_pend[i] = 1'b1;
          m_pendv[i] = s;
        end
        expv[i] = {m_step[i], m_dir[i], m_err[i], m_filt[i]};
      end
    end
  endtask

  task automatic tick(input logic [1:0] p, input logic r);
    @(negedge clk);
    #1;
    {a_in, b_in} = p;
    rst = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
  endtask

  task automatic clear_stats();
    for (int u = 0; u < 3; u++) begin
      nstep[u] = 0; ndn[u] = 0; nerr[u] = 0;
    end
    mm = 0; kedge = 0; first_k = -1;
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    for (int c = 0; c < n; c++) begin
      tick(p, 1'b1);
      kedge++;
      for (int u = 0; u < 3; u++) begin
        if (obs[u] !== expv[u]) begin
          if (mm == 0) begin
            mm_u = u; mm_got = obs[u]; mm_want = expv[u]; mm_k = kedge;
          end
          mm++;
        end
        if (obs[u][4] === 1'b1) begin
          nstep[u]++;
          if (obs[u][3] === 1'b1) ndn[u]++;
          if (u == 0 && first_k < 0) first_k = kedge;
        end
        if (obs[u][2] === 1'b1) nerr[u]++;
      end
    end
  endtask

  task automatic reset_to(input logic [1:0] p);
    tick(p, 1'b0);
    tick(p, 1'b0);
    clear_stats();
    hold(p, 20);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(2'($urandom_range(0, 3)), 1'b0);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (obs[u] !== 5'b0) begin
          failures++;
          $display("FAIL reset_outputs u%0d got=%b want=00000", u, obs[u]);
        end
      end
    end
    reset_to(2'b00);
    checks++;
    if (mm !== 0 || nstep[0] !== 0 || nerr[0] !== 0) begin
      failures++;
      $display("FAIL reset_idle mism=%0d steps=%0d errs=%0d want 0/0/0", mm, nstep[0], nerr[0]);
    end
  endtask

  task automatic test_cw();
    reset_to(2'b00);
    clear_stats();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    checks++;
    if (mm !== 0) begin
      failures++;
      $display("FAIL cw_model mism=%0d u%0d edge%0d got=%b want=%b", mm, mm_u, mm_k, mm_got, mm_want);
    end
    checks++;
    if (nstep[0] !== 4 || ndn[0] !== 0) begin
      failures++;
      $display("FAIL cw_steps got=%0d/%0d want=4/0", nstep[0], ndn[0]);
    end
    checks++;
    if (first_k !== 7) begin
      failures++;
      $display("FAIL cw_latency got=edge%0d want=edge7", first_k);
    end
    checks++;
    if (cnt4 !== 4'd4) begin
      failures++;
      $display("FAIL cw_counter got=%0d want=4", cnt4);
    end
  endtask

  task automatic test_ccw();
    reset_to(2'b00);
    clear_stats();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    checks++;
    if (mm !== 0) begin
      failures++;
      $display("FAIL ccw_model mism=%0d u%0d edge%0d got=%b want=%b", mm, mm_u, mm_k, mm_got, mm_want);
    end
    checks++;
    if (nstep[0] !== 4 || ndn[0] !== 4) begin
      failures++;
      $display("FAIL ccw_steps got=%0d/%0d want=4/4", nstep[0], ndn[0]);
    end
    checks++;
    if (cnt4 !== 4'd12) begin
      failures++;
      $display("FAIL ccw_counter got=%0d want=12", cnt4);
    end
  endtask

  task automatic test_bounce();
    reset_to(2'b00);
    clear_stats();
    for (int r = 0; r < 5; r++) begin
      hold(2'b10, 3);
      hold(2'b00, 5);
    end
    checks++;
    if (mm !== 0 || nstep[0] !== 0 || nerr[0] !== 0 || ab0 !== 2'b00) begin
      failures++;
      $display("FAIL bounce_reject mism=%0d steps=%0d errs=%0d ab=%b want 0/0/0/00", mm, nstep[0], nerr[0], ab0);
    end
    clear_stats();
    hold(2'b10, 4);
    hold(2'b00, 10);
    checks++;
    if (mm !== 0 || nstep[0] !== 2 || ndn[0] !== 1 || dir0 !== 1'b0) begin
      failures++;
      $display("FAIL bounce_accept mism=%0d steps=%0d down=%0d dir=%b want 0/2/1/0", mm, nstep[0], ndn[0], dir0);
    end
  endtask

  task automatic test_illegal();
    reset_to(2'b00);
    clear_stats();
    hold(2'b11, 10);
    checks++;
    if (mm !== 0 || nerr[0] !== 1 || nstep[0] !== 0 || ab0 !== 2'b11 || dir0 !== 1'b0) begin
      failures++;
      $display("FAIL illegal_00_11 mism=%0d errs=%0d steps=%0d ab=%b dir=%b want 0/1/0/11/0", mm, nerr[0], nstep[0], ab0, dir0);
    end
    reset_to(2'b00);
    hold(2'b10, 10);
    clear_stats();
    hold(2'b01, 10);
    checks++;
    if (mm !== 0 || nerr[0] !== 1 || nstep[0] !== 0 || ab0 !== 2'b01 || dir0 !== 1'b1) begin
      failures++;
      $display("FAIL illegal_dir_hold mism=%0d errs=%0d steps=%0d ab=%b dir=%b want 0/1/0/01/1", mm, nerr[0], nstep[0], ab0, dir0);
    end
    reset_to(2'b11);
    checks++;
    if (mm !== 0 || nerr[0] !== 0 || nstep[0] !== 0 || ab0 !== 2'b11) begin
      failures++;
      $display("FAIL powerup_silent mism=%0d errs=%0d steps=%0d ab=%b want 0/0/0/11", mm, nerr[0], nstep[0], ab0);
    end
    clear_stats();
    hold(2'b10, 10);
    checks++;
    if (mm !== 0 || nstep[0] !== 1 || ndn[0] !== 0) begin
      failures++;
      $display("FAIL powerup_first_step mism=%0d steps=%0d down=%0d want 0/1/0", mm, nstep[0], ndn[0]);
    end
  endtask

  task automatic test_x1();
    reset_to(2'b00);
    clear_stats();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    checks++;
    if (mm !== 0 || nstep[1] !== 1 || ndn[1] !== 0) begin
      failures++;
      $display("FAIL x1_cw mism=%0d steps=%0d down=%0d want 0/1/0", mm, nstep[1], ndn[1]);
    end
    clear_stats();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    checks++;
    if (mm !== 0 || nstep[1] !== 1 || ndn[1] !== 1 || dir1 !== 1'b1) begin
      failures++;
      $display("FAIL x1_ccw mism=%0d steps=%0d down=%0d dir=%b want 0/1/1/1", mm, nstep[1], ndn[1], dir1);
    end
  endtask

  task automatic test_reset_mid();
    reset_to(2'b00);
    clear_stats();
    hold(2'b01, 2);
    tick(2'b01, 1'b0);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (obs[u] !== 5'b0) begin
        failures++;
        $display("FAIL midreset_outputs u%0d got=%b want=00000", u, obs[u]);
      end
    end
    clear_stats();
    hold(2'b01, 20);
    checks++;
    if (mm !== 0 || nstep[0] !== 0 || nerr[0] !== 0 || nstep[2] !== 0 || ab0 !== 2'b01) begin
      failures++;
      $display("FAIL midreset_adopt mism=%0d steps=%0d errs=%0d ab=%b want 0/0/0/01", mm, nstep[0], nerr[0], ab0);
    end
    clear_stats();
    hold(2'b11, 10);
    checks++;
    if (mm !== 0 || nstep[0] !== 1 || ndn[0] !== 0) begin
      failures++;
      $display("FAIL midreset_track mism=%0d steps=%0d down=%0d want 0/1/0", mm, nstep[0], ndn[0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] v;
    logic [1:0] g;
    int r;
    v = seq[$urandom_range(0, 3)];
    reset_to(v);
    clear_stats();
    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        v = seq[(pos(v) + (($urandom_range(0, 1) == 1) ? 3 : 1)) % 4];
      end else if (r < 82) begin
        v = v ^ 2'b11;
      end else if (r < 96) begin
        g = v ^ 2'($urandom_range(1, 3));
        hold(g, $urandom_range(1, 3));
      end else begin
        tick(v, 1'b0);
        hold(v, 20);
      end
      hold(v, $urandom_range(1, 12));
    end
    checks++;
    if (mm !== 0) begin
      failures++;
      $display("FAIL random_model mism=%0d u%0d got=%b want=%b", mm, mm_u, mm_got, mm_want);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_in = 1'b0;
    b_in = 1'b0;
    hq.push_back(2'b00);
    hq.push_back(2'b00);
    test_reset();
    test_cw();
    test_ccw();
    test_bounce();
    test_illegal();
    test_x1();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
